// File: rtl/sd_mirror_trk_pkg.sv
// Shared defaults for the mirror tracker slice.
// Every width is derived from the module parameters; this package only holds their defaults.
package sd_mirror_trk_pkg;

  localparam int SD_MIRROR_DEF    = 2;
  localparam int SD_WIDTH_DEF     = 8;
  localparam bit SD_CHK_DEF       = 1'b1;
  localparam int SD_CNT_WIDTH_DEF = 16;

endpackage

// File: rtl/sd_sat_cnt.sv
// Saturating up-counter: increments on inc and sticks at all-ones.
// The counter never wraps back to zero.
module sd_sat_cnt #(
  parameter int width = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [width-1:0] count
);

  localparam logic [width-1:0] ONE = width'(1);

  logic [width-1:0] count_r;
  logic             at_max_s;

  assign at_max_s = &count_r;

  // Count register; it holds once all bits are set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r <= '0;
    end else if (inc && !at_max_s) begin
      count_r <= count_r + ONE;
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/sd_mirror_trk.sv
// One-to-many mirror: a consumer beat is offered to every selected destination and retired
// once all of them have accepted it. An optional checker flags beats that change mid-delivery.
module sd_mirror_trk
  import sd_mirror_trk_pkg::*;
#(
  parameter int mirror    = SD_MIRROR_DEF,
  parameter int width     = SD_WIDTH_DEF,
  parameter bit chk       = SD_CHK_DEF,
  parameter int cnt_width = SD_CNT_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 c_srdy,
  output logic                 c_drdy,
  input  logic [width-1:0]     c_data,
  input  logic [mirror-1:0]    c_dst_vld,
  output logic [mirror-1:0]    p_srdy,
  input  logic [mirror-1:0]    p_drdy,
  output logic [width-1:0]     p_data,
  output logic                 busy,
  output logic                 err_chg,
  input  logic                 err_clr,
  output logic [cnt_width-1:0] stall_cnt
);

  logic [mirror-1:0] sent_r;
  logic [mirror-1:0] sent_nxt_s;
  logic [mirror-1:0] pending_s;
  logic [mirror-1:0] accept_s;
  logic              busy_r;
  logic              beat_done_s;
  logic              stall_s;

  // p_srdy depends only on c_srdy and the delivery record, never on p_drdy.
  assign pending_s   = c_dst_vld & ~sent_r;
  assign p_srdy      = {mirror{c_srdy}} & pending_s;
  assign accept_s    = pending_s & p_drdy;
  assign c_drdy      = &(~pending_s | p_drdy);
  assign beat_done_s = c_srdy & c_drdy;
  assign stall_s     = c_srdy & ~c_drdy;
  assign p_data      = c_data;

  // Next delivery record: cleared on completion, accumulated on partial progress.
  always_comb begin
    sent_nxt_s = sent_r;
    if (beat_done_s) begin
      sent_nxt_s = '0;
    end else if (c_srdy) begin
      sent_nxt_s = sent_r | accept_s;
    end else begin
      sent_nxt_s = sent_r;
    end
  end

  // Delivery record and its registered busy summary.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sent_r <= '0;
      busy_r <= 1'b0;
    end else begin
      sent_r <= sent_nxt_s;
      busy_r <= |sent_nxt_s;
    end
  end

  assign busy = busy_r;

  sd_sat_cnt #(
    .width(cnt_width)
  ) u_stall_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (stall_s),
    .count(stall_cnt)
  );

  if (chk) begin : g_chk
    logic [width-1:0]  cap_data_r;
    logic [mirror-1:0] cap_dst_r;
    logic              err_r;
    logic              set_s;

    assign set_s = busy_r & (~c_srdy | (c_data != cap_data_r) | (c_dst_vld != cap_dst_r));

    // Snapshot the beat on its first stalled cycle; sticky error where a set beats a clear.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cap_data_r <= '0;
        cap_dst_r  <= '0;
        err_r      <= 1'b0;
      end else begin
        if (stall_s && !busy_r) begin
          cap_data_r <= c_data;
          cap_dst_r  <= c_dst_vld;
        end else begin
          cap_data_r <= cap_data_r;
          cap_dst_r  <= cap_dst_r;
        end
        if (set_s) begin
          err_r <= 1'b1;
        end else if (err_clr) begin
          err_r <= 1'b0;
        end else begin
          err_r <= err_r;
        end
      end
    end

    assign err_chg = err_r;
  end else begin : g_no_chk
    logic unused_clr_s;
    assign unused_clr_s = err_clr;
    assign err_chg      = 1'b0;
  end

endmodule

// File: tb/tb_sd_mirror_trk.sv
// Directed bench for sd_mirror_trk: a vector table on a 3-way instance plus hand sequences
// for reset mid-beat and counter saturation on a 2-way, checker-less, 2-bit-counter instance.
module tb_sd_mirror_trk;

  logic        clk = 1'b0;
  logic        reset;
  logic        c_srdy, c_drdy, busy, err_chg, err_clr;
  logic [7:0]  c_data, p_data;
  logic [2:0]  c_dst_vld, p_srdy, p_drdy;
  logic [15:0] stall_cnt;

  logic        s_srdy, s_c_drdy, s_busy, s_err_chg, s_err_clr;
  logic [7:0]  s_data, s_p_data;
  logic [1:0]  s_dst, s_p_srdy, s_p_drdy, s_stall;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sd_mirror_trk #(.mirror(3), .width(8), .chk(1'b1), .cnt_width(16)) u_dut (
    .clk(clk), .reset(reset), .c_srdy(c_srdy), .c_drdy(c_drdy), .c_data(c_data),
    .c_dst_vld(c_dst_vld), .p_srdy(p_srdy), .p_drdy(p_drdy), .p_data(p_data),
    .busy(busy), .err_chg(err_chg), .err_clr(err_clr), .stall_cnt(stall_cnt)
  );

  sd_mirror_trk #(.mirror(2), .width(8), .chk(1'b0), .cnt_width(2)) u_sat (
    .clk(clk), .reset(reset), .c_srdy(s_srdy), .c_drdy(s_c_drdy), .c_data(s_data),
    .c_dst_vld(s_dst), .p_srdy(s_p_srdy), .p_drdy(s_p_drdy), .p_data(s_p_data),
    .busy(s_busy), .err_chg(s_err_chg), .err_clr(s_err_clr), .stall_cnt(s_stall)
  );

  typedef struct {
    logic        srdy;
    logic [7:0]  data;
    logic [2:0]  dst;
    logic [2:0]  drdy;
    logic        clr;
    logic [2:0]  e_psrdy;
    logic        e_cdrdy;
    logic        e_busy;
    logic        e_err;
    logic [15:0] e_stall;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic srdy, input logic [7:0] data, input logic [2:0] dst,
                              input logic [2:0] drdy, input logic clr, input logic [2:0] e_psrdy,
                              input logic e_cdrdy, input logic e_busy, input logic e_err,
                              input logic [15:0] e_stall);
    vec_t v;
    v.srdy = srdy; v.data = data; v.dst = dst; v.drdy = drdy; v.clr = clr;
    v.e_psrdy = e_psrdy; v.e_cdrdy = e_cdrdy; v.e_busy = e_busy; v.e_err = e_err;
    v.e_stall = e_stall;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    // srdy data dst drdy clr | p_srdy c_drdy busy err stall  (busy/err/stall are pre-edge state)
    vecs.push_back(mk(1'b0, 8'h00, 3'b000, 3'b000, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 16'd0));
    vecs.push_back(mk(1'b1, 8'hA5, 3'b111, 3'b111, 1'b0, 3'b111, 1'b1, 1'b0, 1'b0, 16'd0));
    vecs.push_back(mk(1'b0, 8'h00, 3'b111, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 16'd0));
    vecs.push_back(mk(1'b1, 8'h5A, 3'b000, 3'b000, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 16'd0));
    vecs.push_back(mk(1'b1, 8'h3C, 3'b111, 3'b001, 1'b0, 3'b111, 1'b0, 1'b0, 1'b0, 16'd0));
    vecs.push_back(mk(1'b1, 8'h3C, 3'b111, 3'b110, 1'b0, 3'b110, 1'b1, 1'b1, 1'b0, 16'd1));
    vecs.push_back(mk(1'b0, 8'h00, 3'b000, 3'b000, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 16'd1));
    vecs.push_back(mk(1'b1, 8'h11, 3'b101, 3'b100, 1'b0, 3'b101, 1'b0, 1'b0, 1'b0, 16'd1));
    vecs.push_back(mk(1'b1, 8'h11, 3'b101, 3'b000, 1'b0, 3'b001, 1'b0, 1'b1, 1'b0, 16'd2));
    vecs.push_back(mk(1'b1, 8'h11, 3'b101, 3'b001, 1'b0, 3'b001, 1'b1, 1'b1, 1'b0, 16'd3));
    vecs.push_back(mk(1'b1, 8'h22, 3'b011, 3'b001, 1'b0, 3'b011, 1'b0, 1'b0, 1'b0, 16'd3));
    vecs.push_back(mk(1'b1, 8'h23, 3'b011, 3'b000, 1'b0, 3'b010, 1'b0, 1'b1, 1'b0, 16'd4));
    vecs.push_back(mk(1'b1, 8'h22, 3'b011, 3'b010, 1'b0, 3'b010, 1'b1, 1'b1, 1'b1, 16'd5));
    vecs.push_back(mk(1'b0, 8'h00, 3'b000, 3'b000, 1'b1, 3'b000, 1'b1, 1'b0, 1'b1, 16'd5));
    vecs.push_back(mk(1'b0, 8'h00, 3'b000, 3'b000, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 16'd5));
    vecs.push_back(mk(1'b1, 8'h44, 3'b110, 3'b100, 1'b0, 3'b110, 1'b0, 1'b0, 1'b0, 16'd5));
    vecs.push_back(mk(1'b0, 8'h44, 3'b110, 3'b000, 1'b1, 3'b000, 1'b0, 1'b1, 1'b0, 16'd6));
    vecs.push_back(mk(1'b1, 8'h44, 3'b110, 3'b010, 1'b0, 3'b010, 1'b1, 1'b1, 1'b1, 16'd6));
    vecs.push_back(mk(1'b0, 8'h00, 3'b000, 3'b000, 1'b1, 3'b000, 1'b1, 1'b0, 1'b1, 16'd6));
    vecs.push_back(mk(1'b0, 8'h00, 3'b000, 3'b000, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 16'd6));

    reset = 1'b1;
    c_srdy = 1'b0; c_data = 8'h00; c_dst_vld = 3'b000; p_drdy = 3'b000; err_clr = 1'b0;
    s_srdy = 1'b0; s_data = 8'h00; s_dst = 2'b00; s_p_drdy = 2'b00; s_err_clr = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("reset busy", 32'(busy), 32'd0);
    check("reset err_chg", 32'(err_chg), 32'd0);
    check("reset stall_cnt", 32'(stall_cnt), 32'd0);
    check("reset c_drdy", 32'(c_drdy), 32'd1);
    check("reset p_srdy", 32'(p_srdy), 32'd0);
    check("reset sat stall_cnt", 32'(s_stall), 32'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      c_srdy = vecs[i].srdy; c_data = vecs[i].data; c_dst_vld = vecs[i].dst;
      p_drdy = vecs[i].drdy; err_clr = vecs[i].clr;
      #1;
      check($sformatf("v%0d p_srdy", i), 32'(p_srdy), 32'(vecs[i].e_psrdy));
      check($sformatf("v%0d c_drdy", i), 32'(c_drdy), 32'(vecs[i].e_cdrdy));
      check($sformatf("v%0d p_data", i), 32'(p_data), 32'(vecs[i].data));
      check($sformatf("v%0d busy", i), 32'(busy), 32'(vecs[i].e_busy));
      check($sformatf("v%0d err_chg", i), 32'(err_chg), 32'(vecs[i].e_err));
      check($sformatf("v%0d stall_cnt", i), 32'(stall_cnt), 32'(vecs[i].e_stall));
      @(negedge clk);
    end

    // Reset in the middle of a beat after destination 1 has been served.
    c_srdy = 1'b1; c_data = 8'h55; c_dst_vld = 3'b111; p_drdy = 3'b010; err_clr = 1'b0;
    #1;
    check("rst-mid first offer", 32'(p_srdy), 32'h7);
    @(negedge clk);
    p_drdy = 3'b000;
    #1;
    check("rst-mid busy before", 32'(busy), 32'd1);
    check("rst-mid p_srdy before", 32'(p_srdy), 32'h5);
    reset = 1'b1;
    #1;
    check("rst-mid busy cleared", 32'(busy), 32'd0);
    check("rst-mid p_srdy reoffer", 32'(p_srdy), 32'h7);
    check("rst-mid stall_cnt", 32'(stall_cnt), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst-mid dst1 after reset", 32'(p_srdy[1]), 32'd1);
    p_drdy = 3'b111;
    #1;
    check("rst-mid c_drdy", 32'(c_drdy), 32'd1);
    @(negedge clk);
    c_srdy = 1'b0; p_drdy = 3'b000; c_dst_vld = 3'b000;
    #1;
    check("rst-mid busy after", 32'(busy), 32'd0);
    check("rst-mid stall after", 32'(stall_cnt), 32'd0);

    // Saturation on the 2-bit counter with five stalled cycles; checker absent.
    s_srdy = 1'b1; s_data = 8'h10; s_dst = 2'b11; s_p_drdy = 2'b01;
    #1;
    check("sat p_srdy", 32'(s_p_srdy), 32'h3);
    check("sat c_drdy", 32'(s_c_drdy), 32'd0);
    @(negedge clk);
    s_p_drdy = 2'b00; s_data = 8'h77;
    #1;
    check("sat busy", 32'(s_busy), 32'd1);
    check("sat stall 1", 32'(s_stall), 32'd1);
    check("sat p_srdy partial", 32'(s_p_srdy), 32'h2);
    @(negedge clk);
    #1;
    check("sat stall 2", 32'(s_stall), 32'd2);
    repeat (3) @(negedge clk);
    #1;
    check("sat stall saturated", 32'(s_stall), 32'd3);
    check("sat err_chg tied", 32'(s_err_chg), 32'd0);
    s_p_drdy = 2'b10;
    #1;
    check("sat complete c_drdy", 32'(s_c_drdy), 32'd1);
    @(negedge clk);
    s_srdy = 1'b0; s_dst = 2'b00; s_p_drdy = 2'b00;
    #1;
    check("sat busy after", 32'(s_busy), 32'd0);
    check("sat stall held", 32'(s_stall), 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sd_mirror_trk.md
SD_MIRROR_TRK -- requirements
Module: sd_mirror_trk

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
  mirror, 2, number of destination channels (>=1)
  width, 8, payload width in bits
  chk, 1, enable the hold-stability checker (0 = checker logic absent, err_chg tied 0)
  cnt_width, 16, width of the saturating stall counter
REQ-002 Ports SHALL be, one per line as name, direction, width, meaning:
  clk  in  1  single clock, rising edge
  reset  in  1  asynchronous, active-high reset
  c_srdy  in  1  consumer-side source ready
  c_drdy  out  1  consumer-side destination ready
  c_data  in  width  payload
  c_dst_vld  in  mirror  destination mask for the current beat
  p_srdy  out  mirror  per-destination source ready
  p_drdy  in  mirror  per-destination destination ready
  p_data  out  width  payload to all destinations
  busy  out  1  beat partially delivered
  err_chg  out  1  sticky: beat changed while partially delivered
  err_clr  in  1  synchronous clear of err_chg
  stall_cnt  out  cnt_width  saturating count of stalled cycles
REQ-003 The block SHALL use one clock; reset SHALL be asynchronous and active-high.

Function
REQ-004 p_data SHALL equal c_data combinationally, with zero latency and no data flop.
REQ-005 A sent[mirror] register SHALL record the destinations that have already accepted the current beat; pending[i] = c_dst_vld[i] & ~sent[i].
REQ-006 p_srdy[i] SHALL be c_srdy & pending[i], and SHALL NOT depend combinationally on any p_drdy bit.
REQ-007 c_drdy SHALL be the AND over i of (~pending[i] | p_drdy[i]).
REQ-008 A beat completes when c_srdy & c_drdy; on completion sent SHALL clear to 0 at the next edge.
REQ-009 When c_srdy & ~c_drdy, sent SHALL be updated to sent | (pending & p_drdy).
REQ-010 When c_srdy=0, sent SHALL hold its value.
REQ-011 Each destination SHALL see exactly one p_srdy&p_drdy transfer per beat for every bit set in c_dst_vld.
REQ-012 c_dst_vld=0 with c_srdy=1 SHALL complete in the same cycle: c_drdy=1, p_srdy=0.
REQ-013 If all destinations accept in the first cycle, the beat SHALL complete in one cycle with no state change.
REQ-014 busy SHALL be |sent (registered).
REQ-015 chk=1: the checker SHALL capture c_data and c_dst_vld on the first partial cycle.
REQ-016 chk=1: while busy, c_srdy=0 or any change to c_data or c_dst_vld SHALL set err_chg at the next edge.
REQ-017 err_clr SHALL clear err_chg; if a set and err_clr occur in the same cycle, set SHALL win.
REQ-018 stall_cnt SHALL increment on every cycle with c_srdy & ~c_drdy, and SHALL saturate at all-ones without wrapping.

Reset
REQ-019 On reset the block SHALL drive sent=0, busy=0, err_chg=0 and stall_cnt=0; p_srdy and c_drdy then follow REQ-006/007 combinationally.
REQ-020 Reset asserted mid-beat SHALL discard the delivery record, so destinations already served SHALL be offered the beat again after reset.

Structure
REQ-021 No shared-package typedefs are required; all widths SHALL derive from the module parameters.
REQ-022 The saturating stall counter SHALL be the sub-module sd_sat_cnt, parameterised by width.
REQ-023 The checker SHALL sit inside a generate block enabled by chk.

Verification
REQ-024 With mirror=3, dst=3'b111 and p_drdy=3'b111, one beat SHALL complete in 1 cycle, each p_srdy pulse SHALL occur once, and stall_cnt SHALL stay 0.
REQ-025 With dst=3'b111, p_drdy=3'b001 in cycle 0 then 3'b110 in cycle 1: cycle 1 SHALL give p_srdy=3'b110, c_drdy=1; busy SHALL be 1 for exactly 1 cycle; stall_cnt SHALL be 1.
REQ-026 With dst=3'b000 and c_srdy=1: c_drdy=1, p_srdy=0.
REQ-027 With a partial beat followed by a c_data change: err_chg SHALL go to 1 the next cycle; err_clr SHALL return it to 0.
REQ-028 With reset asserted while sent=3'b010: sent SHALL be 0 immediately, and destination 1 SHALL receive the beat again after reset.
REQ-029 With cnt_width=2 and 5 stalled cycles: stall_cnt SHALL be 3 (saturated).
